gpio_pad_ctrl: RTL and testbench
================================

// Module: gpio_pad_ctrl
// PURPOSE
//  Core-side controller for one SUMB-style GPIO pad cell.
//  - Drives the pad control pins: DO, OEN (active-low output enable), REN (active-low pull enable) and IE.
//  - Synchronises and glitch-filters the pad's DI return into a clean core input with edge pulses.
//  - While driving, checks DI readback against DO and flags bus contention.
//  - Sequences output-to-input turnaround so IE is never enabled on a floating/settling pad.
// PARAMETERS
//  SYNC_STAGES    2  flops in the pad_di synchroniser (>=2)
//  FILT_CYCLES    4  consecutive stable synced cycles required before din changes (>=1)
//  SETTLE_CYCLES  4  cycles after any pad_do/pad_oen change before readback compare (>=SYNC_STAGES+1)
//  TURN_CYCLES    2  cycles pad_ie held low after output release (>=1)
//  CW             8  width of internal counters; every *_CYCLES parameter < 2**CW
// PORTS
//  clk             in   1  single clock domain
//  rst             in   1  synchronous reset, active-high
//  oe_req          in   1  1 = drive pad, 0 = input mode
//  dout            in   1  value to drive while oe_req=1
//  pull_en         in   1  enable pad weak pull in input mode
//  in_en           in   1  enable pad input receiver in input mode
//  clr_contention  in   1  clears the sticky contention flag
//  pad_do          out  1  to pad DO
//  pad_oen         out  1  to pad OEN (0 = driving)
//  pad_ren         out  1  to pad REN (0 = pull on)
//  pad_ie          out  1  to pad IE
//  pad_di          in   1  from pad DI (asynchronous)
//  din             out  1  filtered pad input
//  din_rise        out  1  1-cycle pulse on din 0->1
//  din_fall        out  1  1-cycle pulse on din 1->0
//  contention      out  1  sticky: readback mismatch while driving
//  busy            out  1  1 in TURN, and in DRIVE until the settle count expires
// BEHAVIOUR
//  Reset values (next clk edge with rst=1):
//  - pad_oen=1, pad_do=0, pad_ren=0, pad_ie=0, din=0, din_rise=0, din_fall=0, contention=0, busy=0.
//  - State=IN. Synchroniser flops and all counters cleared.
//  - rst mid-operation releases the pad (pad_oen=1) at that same edge.
//  All outputs are registered; pad pins follow requests with 1-cycle latency.
//  FSM states: IN, DRIVE, TURN.
//  IN:
//  - pad_oen=1, pad_ren=~pull_en, pad_ie=in_en.
//  - oe_req=1 -> DRIVE: pad_oen=0, pad_do=dout, pad_ren=1, pad_ie=1; settle counter cleared.
//  DRIVE:
//  - pad_do tracks dout with 1-cycle latency; any dout change clears the settle counter.
//  - Settle counter saturates at SETTLE_CYCLES; busy=1 until saturation.
//  - Once saturated: sync_di != pad_do sets contention.
//  - oe_req=0 -> TURN: pad_oen=1, pad_ie=0, pad_ren=~pull_en; turn counter cleared.
//  TURN:
//  - pad_ie=0 for TURN_CYCLES cycles; pad_ren=~pull_en.
//  - Then -> IN with pad_ie=in_en; filter counter cleared; din keeps its last value.
//  - oe_req=1 during TURN -> DRIVE on the next edge (abort turnaround).
//  Filter:
//  - Counter increments while sync_di != din and clears when sync_di == din.
//  - When the count reaches FILT_CYCLES: din<=sync_di, the edge pulse fires in the same cycle, counter clears.
//  - Frozen (counter held 0, din held) while pad_ie=0 and during DRIVE.
//  contention:
//  - Sticky until clr_contention=1.
//  - Set and clear in the same cycle: set wins.
//  Counters saturate and never wrap.
// TESTING
//  1. rst=1 for 3 cycles -> pad_oen=1, pad_ren=0, pad_ie=0, din=0, contention=0, busy=0.
//  2. IN, in_en=1, pad_di 0->1 held for 10 cycles -> din=1 exactly 6 cycles after the change, din_rise high 1 cycle.
//     A 3-cycle 1-glitch -> din stays 0, no pulse.
//  3. oe_req=1, dout=1, pad_di looped from pad_do:
//     - next edge: pad_oen=0, pad_do=1, pad_ren=1;
//     - busy low 4 cycles later;
//     - contention stays 0.
//  4. DRIVE dout=1, pad_di forced 0 -> contention=1 after settle.
//     clr_contention pulse while mismatch persists -> contention remains 1.
//  5. Turnaround, pull_en=1:
//     - oe_req 1->0 -> pad_oen=1, pad_ren=0, pad_ie=0 for 2 cycles, then pad_ie=1.
//     - Repeat with oe_req re-raised in TURN cycle 1 -> pad_oen=0 next edge.
//  6. rst asserted in DRIVE with dout=1 -> pad_oen=1, pad_do=0 at that edge; no contention set.

Source files
------------

// File: rtl/gpio_pad_ctrl_if.sv
// Core/pad signal bundle for one GPIO pad controller.
// master: the core and pad side that drive requests and the pad DI return.
// slave:  the controller that drives the pad pins and the filtered status.
interface gpio_pad_ctrl_if;
  logic oe_req;
  logic dout;
  logic pull_en;
  logic in_en;
  logic clr_contention;
  logic pad_do;
  logic pad_oen;
  logic pad_ren;
  logic pad_ie;
  logic pad_di;
  logic din;
  logic din_rise;
  logic din_fall;
  logic contention;
  logic busy;

  modport master (
    output oe_req, dout, pull_en, in_en, clr_contention, pad_di,
    input  pad_do, pad_oen, pad_ren, pad_ie, din, din_rise, din_fall, contention, busy
  );

  modport slave (
    input  oe_req, dout, pull_en, in_en, clr_contention, pad_di,
    output pad_do, pad_oen, pad_ren, pad_ie, din, din_rise, din_fall, contention, busy
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// Core-side controller for a single GPIO pad cell: drives DO/OEN/REN/IE,
// filters the DI return, checks readback while driving and sequences the
// output-to-input turnaround so IE never sees a settling pad.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IN    | pad released, receiver enabled by in_en, pull by pull_en
// ST_DRIVE | pad driven from dout, readback checked once settled
// ST_TURN  | pad released, IE held low while the pad line settles
module gpio_pad_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TURN_CYCLES   = 2,
  parameter int CW            = 8
) (
  input logic           clk,
  input logic           rst,
  gpio_pad_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IN    = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] TURN_LOAD   = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] FILT_LAST   = CW'(FILT_CYCLES - 1);
  localparam logic [CW-1:0] ONE         = CW'(1);

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_di;

  // settle and turn timers are down-counters; zero is the terminal count
  logic [CW-1:0] settle_cnt;
  logic [CW-1:0] settle_nxt;
  logic [CW-1:0] turn_cnt;
  logic [CW-1:0] turn_nxt;
  logic [CW-1:0] filt_cnt;

  logic pad_do_q;
  logic pad_oen_q;
  logic pad_ren_q;
  logic pad_ie_q;
  logic busy_q;
  logic din_q;
  logic din_rise_q;
  logic din_fall_q;
  logic contention_q;

  logic pad_do_nxt;
  logic pad_oen_nxt;
  logic pad_ren_nxt;
  logic pad_ie_nxt;
  logic busy_nxt;

  logic mismatch;
  logic filt_frozen;

  assign sync_di = sync_q[SYNC_STAGES-1];

  // Readback is only meaningful once the settle timer has run out in DRIVE.
  assign mismatch = (state == ST_DRIVE) && (settle_cnt == '0) && (sync_di != pad_do_q);

  // The filter must not chase the pad while we drive it or the receiver is off.
  assign filt_frozen = (state != ST_IN) || !pad_ie_q;

  // Multi-flop synchroniser for the asynchronous pad DI return.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pad_di};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, timer reloads and next values of the registered pad pins.
  always_comb begin
    state_nxt   = state;
    settle_nxt  = settle_cnt;
    turn_nxt    = turn_cnt;
    pad_do_nxt  = pad_do_q;
    pad_oen_nxt = 1'b1;
    pad_ren_nxt = ~bus.pull_en;
    pad_ie_nxt  = bus.in_en;

    case (state)
      ST_IN: begin
        if (bus.oe_req) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (!bus.oe_req) state_nxt = ST_TURN;
      end
      ST_TURN: begin
        // a new drive request aborts the turnaround immediately
        if (bus.oe_req) state_nxt = ST_DRIVE;
        else if (turn_cnt <= ONE) state_nxt = ST_IN;
      end
      default: state_nxt = ST_IN;
    endcase

    case (state_nxt)
      ST_DRIVE: begin
        pad_oen_nxt = 1'b0;
        pad_do_nxt  = bus.dout;
        pad_ren_nxt = 1'b1;
        pad_ie_nxt  = 1'b1;
        // any new value on the line restarts the settle window
        if ((state != ST_DRIVE) || (bus.dout != pad_do_q)) settle_nxt = SETTLE_LOAD;
        else if (settle_cnt != '0) settle_nxt = settle_cnt - ONE;
      end
      ST_TURN: begin
        pad_ie_nxt = 1'b0;
        if (state != ST_TURN) turn_nxt = TURN_LOAD;
        else if (turn_cnt != '0) turn_nxt = turn_cnt - ONE;
      end
      default: ;
    endcase

    busy_nxt = (state_nxt == ST_TURN) || ((state_nxt == ST_DRIVE) && (settle_nxt != '0));
  end

  // Registered pad pins, timers and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_do_q   <= 1'b0;
      pad_oen_q  <= 1'b1;
      pad_ren_q  <= 1'b0;
      pad_ie_q   <= 1'b0;
      busy_q     <= 1'b0;
      settle_cnt <= '0;
      turn_cnt   <= '0;
    end else begin
      pad_do_q   <= pad_do_nxt;
      pad_oen_q  <= pad_oen_nxt;
      pad_ren_q  <= pad_ren_nxt;
      pad_ie_q   <= pad_ie_nxt;
      busy_q     <= busy_nxt;
      settle_cnt <= settle_nxt;
      turn_cnt   <= turn_nxt;
    end
  end

  // Glitch filter: din follows sync_di only after FILT_CYCLES stable disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_cnt   <= '0;
      din_q      <= 1'b0;
      din_rise_q <= 1'b0;
      din_fall_q <= 1'b0;
    end else begin
      din_rise_q <= 1'b0;
      din_fall_q <= 1'b0;
      if (filt_frozen || (sync_di == din_q)) begin
        filt_cnt <= '0;
      end else if (filt_cnt >= FILT_LAST) begin
        filt_cnt   <= '0;
        din_q      <= sync_di;
        din_rise_q <= sync_di;
        din_fall_q <= ~sync_di;
      end else begin
        filt_cnt <= filt_cnt + ONE;
      end
    end
  end

  // Sticky contention flag; a fresh mismatch beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      contention_q <= 1'b0;
    end else if (mismatch) begin
      contention_q <= 1'b1;
    end else if (bus.clr_contention) begin
      contention_q <= 1'b0;
    end
  end

  assign bus.pad_do     = pad_do_q;
  assign bus.pad_oen    = pad_oen_q;
  assign bus.pad_ren    = pad_ren_q;
  assign bus.pad_ie     = pad_ie_q;
  assign bus.busy       = busy_q;
  assign bus.din        = din_q;
  assign bus.din_rise   = din_rise_q;
  assign bus.din_fall   = din_fall_q;
  assign bus.contention = contention_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: reset, input filtering, drive/settle,
// contention, turnaround and reset while driving.
module tb_gpio_pad_ctrl;

  logic clk;
  logic rst;
  logic loop_en;
  logic di_drv;
  int   n_tests;
  int   n_fail;

  gpio_pad_ctrl_if bus ();

  assign bus.pad_di = loop_en ? bus.pad_do : di_drv;

  gpio_pad_ctrl #(
    .SYNC_STAGES  (2),
    .FILT_CYCLES  (4),
    .SETTLE_CYCLES(4),
    .TURN_CYCLES  (2),
    .CW           (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    loop_en = 1'b0;
    di_drv = 1'b0;
    bus.oe_req = 1'b0;
    bus.dout = 1'b0;
    bus.pull_en = 1'b0;
    bus.in_en = 1'b0;
    bus.clr_contention = 1'b0;

    // reset
    tick(3);
    check("rst_oen", bus.pad_oen, 1'b1);
    check("rst_do", bus.pad_do, 1'b0);
    check("rst_ren", bus.pad_ren, 1'b0);
    check("rst_ie", bus.pad_ie, 1'b0);
    check("rst_din", bus.din, 1'b0);
    check("rst_cont", bus.contention, 1'b0);
    check("rst_busy", bus.busy, 1'b0);

    // input mode, rising edge through the filter
    rst = 1'b0;
    bus.in_en = 1'b1;
    tick(2);
    check("in_ie", bus.pad_ie, 1'b1);
    check("in_ren_nopull", bus.pad_ren, 1'b1);
    check("in_oen", bus.pad_oen, 1'b1);
    di_drv = 1'b1;
    tick(5);
    check("rise_early_din", bus.din, 1'b0);
    tick(1);
    check("rise_din", bus.din, 1'b1);
    check("rise_pulse", bus.din_rise, 1'b1);
    tick(1);
    check("rise_pulse_end", bus.din_rise, 1'b0);
    check("rise_din_hold", bus.din, 1'b1);
    tick(3);

    // falling edge
    di_drv = 1'b0;
    tick(5);
    check("fall_early_din", bus.din, 1'b1);
    tick(1);
    check("fall_din", bus.din, 1'b0);
    check("fall_pulse", bus.din_fall, 1'b1);
    tick(3);

    // 3-cycle glitch must be rejected
    di_drv = 1'b1;
    tick(3);
    di_drv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_din", bus.din, 1'b0);
      check("glitch_rise", bus.din_rise, 1'b0);
    end

    // drive with loopback
    loop_en = 1'b1;
    bus.dout = 1'b1;
    bus.oe_req = 1'b1;
    tick(1);
    check("drv_oen", bus.pad_oen, 1'b0);
    check("drv_do", bus.pad_do, 1'b1);
    check("drv_ren", bus.pad_ren, 1'b1);
    check("drv_ie", bus.pad_ie, 1'b1);
    check("drv_busy0", bus.busy, 1'b1);
    tick(3);
    check("drv_busy3", bus.busy, 1'b1);
    tick(1);
    check("drv_busy4", bus.busy, 1'b0);
    tick(4);
    check("drv_cont", bus.contention, 1'b0);

    // dout change restarts settle
    bus.dout = 1'b0;
    tick(1);
    check("chg_do", bus.pad_do, 1'b0);
    check("chg_busy", bus.busy, 1'b1);
    tick(3);
    check("chg_busy3", bus.busy, 1'b1);
    tick(1);
    check("chg_busy4", bus.busy, 1'b0);
    check("chg_cont", bus.contention, 1'b0);
    bus.dout = 1'b1;
    tick(5);
    check("chg2_busy", bus.busy, 1'b0);
    check("chg2_cont", bus.contention, 1'b0);

    // contention: pad held low while driving 1
    loop_en = 1'b0;
    di_drv = 1'b0;
    tick(2);
    check("cont_pre", bus.contention, 1'b0);
    tick(1);
    check("cont_set", bus.contention, 1'b1);
    bus.clr_contention = 1'b1;
    tick(1);
    bus.clr_contention = 1'b0;
    check("cont_set_wins", bus.contention, 1'b1);
    tick(1);
    check("cont_sticky", bus.contention, 1'b1);
    loop_en = 1'b1;
    tick(3);
    bus.clr_contention = 1'b1;
    tick(1);
    bus.clr_contention = 1'b0;
    check("cont_clr", bus.contention, 1'b0);

    // turnaround with pull enabled
    bus.pull_en = 1'b1;
    bus.oe_req = 1'b0;
    tick(1);
    check("turn_oen", bus.pad_oen, 1'b1);
    check("turn_ren", bus.pad_ren, 1'b0);
    check("turn_ie0", bus.pad_ie, 1'b0);
    check("turn_busy", bus.busy, 1'b1);
    tick(1);
    check("turn_ie1", bus.pad_ie, 1'b0);
    tick(1);
    check("turn_ie_back", bus.pad_ie, 1'b1);
    check("turn_busy_end", bus.busy, 1'b0);
    check("turn_ren_in", bus.pad_ren, 1'b0);
    check("turn_din_hold", bus.din, 1'b0);

    // aborted turnaround
    bus.oe_req = 1'b1;
    tick(6);
    check("abort_pre_oen", bus.pad_oen, 1'b0);
    bus.oe_req = 1'b0;
    tick(1);
    check("abort_turn_ie", bus.pad_ie, 1'b0);
    bus.oe_req = 1'b1;
    tick(1);
    check("abort_oen", bus.pad_oen, 1'b0);
    check("abort_ie", bus.pad_ie, 1'b1);
    check("abort_busy", bus.busy, 1'b1);

    // reset while driving 1 with a pending mismatch
    tick(5);
    loop_en = 1'b0;
    di_drv = 1'b0;
    tick(2);
    check("rdrv_pre_cont", bus.contention, 1'b0);
    check("rdrv_pre_oen", bus.pad_oen, 1'b0);
    rst = 1'b1;
    tick(1);
    check("rdrv_oen", bus.pad_oen, 1'b1);
    check("rdrv_do", bus.pad_do, 1'b0);
    check("rdrv_cont", bus.contention, 1'b0);
    check("rdrv_busy", bus.busy, 1'b0);
    rst = 1'b0;
    bus.oe_req = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
